recirculador_param: RTL and testbench



---
 rtl/recirculador_param.sv | 128 ++++++++++++
 tb/tb_recirculador_param.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/recirculador_param.sv
// Parametrised lane recirculator: steers each valid word to a per-lane FWFT FIFO
// (active path) or to a one-stage register (desactivado path), with a drain-aware mode FSM.
module recirculador_param #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         active,
   input  logic [NUM_CH-1:0]            valid_in,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_CH-1:0]            ready_in,
   output logic [NUM_CH-1:0]            valid_out_activo,
   output logic [NUM_CH*DATA_WIDTH-1:0] data_out_activo,
   output logic [NUM_CH-1:0]            valid_out_desactivado,
   output logic [NUM_CH*DATA_WIDTH-1:0] data_out_desactivado,
   output logic [NUM_CH-1:0]            fifo_full,
   output logic [NUM_CH-1:0]            fifo_empty,
   output logic [1:0]                   state,
   output logic [CNT_WIDTH-1:0]         recirc_count,
   output logic                         overflow_err
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam int unsigned PC_W  = $clog2(NUM_CH + 1);
   localparam int unsigned SUM_W = CNT_WIDTH + PC_W;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_RECIRC = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] mem    [NUM_CH][DEPTH];
   logic [PTR_W-1:0]      wr_ptr [NUM_CH];
   logic [PTR_W-1:0]      rd_ptr [NUM_CH];
   logic [OCC_W-1:0]      occ    [NUM_CH];

   logic [NUM_CH-1:0] push_c;
   logic [NUM_CH-1:0] pop_c;
   logic [NUM_CH-1:0] divert_c;
   logic [NUM_CH-1:0] ovf_c;
   logic [PC_W-1:0]   pc_c;
   logic [SUM_W-1:0]  sum_c;

   assign state = state_q;

   // Flags and head words come straight from the FIFO registers
   always_comb begin
      fifo_full        = '0;
      fifo_empty       = '0;
      valid_out_activo = '0;
      data_out_activo  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         fifo_full[i]        = (occ[i] == OCC_W'(DEPTH));
         fifo_empty[i]       = (occ[i] == '0);
         valid_out_activo[i] = (occ[i] != '0);
         data_out_activo[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][rd_ptr[i]];
      end
   end

   // Routing decision: fullness is judged before any same-cycle pop
   always_comb begin
      push_c   = '0;
      pop_c    = '0;
      divert_c = '0;
      ovf_c    = '0;
      pc_c     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         push_c[i]   = valid_in[i] && (state_q == ST_ACTIVE) && !fifo_full[i];
         ovf_c[i]    = valid_in[i] && (state_q == ST_ACTIVE) && fifo_full[i];
         divert_c[i] = valid_in[i] && !push_c[i];
         pop_c[i]    = valid_out_activo[i] && ready_in[i];
         pc_c        = pc_c + PC_W'(divert_c[i]);
      end
      sum_c = SUM_W'(recirc_count) + SUM_W'(pc_c);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q               <= ST_RECIRC;
         valid_out_desactivado <= '0;
         data_out_desactivado  <= '0;
         recirc_count          <= '0;
         overflow_err          <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            occ[i]    <= '0;
            for (int j = 0; j < DEPTH; j++) mem[i][j] <= '0;
         end
      end else begin
         // Mode machine; DRAIN leaves only once the registered flags show all FIFOs empty
         case (state_q)
            ST_RECIRC: if (active) state_q <= ST_ACTIVE;
            ST_ACTIVE: if (!active) state_q <= ST_DRAIN;
            ST_DRAIN: begin
               if (active)           state_q <= ST_ACTIVE;
               else if (&fifo_empty) state_q <= ST_RECIRC;
            end
            default: state_q <= ST_RECIRC;
         endcase

         for (int i = 0; i < NUM_CH; i++) begin
            if (push_c[i]) begin
               mem[i][wr_ptr[i]] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
               wr_ptr[i]         <= wr_ptr[i] + PTR_W'(1);
            end
            if (pop_c[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            if (push_c[i] && !pop_c[i])      occ[i] <= occ[i] + OCC_W'(1);
            else if (!push_c[i] && pop_c[i]) occ[i] <= occ[i] - OCC_W'(1);

            valid_out_desactivado[i] <= divert_c[i];
            data_out_desactivado[i*DATA_WIDTH +: DATA_WIDTH] <=
               divert_c[i] ? data_in[i*DATA_WIDTH +: DATA_WIDTH] : DATA_WIDTH'(0);
         end

         recirc_count <= (sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(sum_c);
         if (|ovf_c) overflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_recirculador_param.sv
// Directed bench for recirculador_param (NUM_CH=4, DATA_WIDTH=8, DEPTH=4, CNT_WIDTH=4).
module tb_recirculador_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        active;
   logic [3:0]  valid_in;
   logic [31:0] data_in;
   logic [3:0]  ready_in;
   logic [3:0]  valid_out_activo;
   logic [31:0] data_out_activo;
   logic [3:0]  valid_out_desactivado;
   logic [31:0] data_out_desactivado;
   logic [3:0]  fifo_full;
   logic [3:0]  fifo_empty;
   logic [1:0]  state;
   logic [3:0]  recirc_count;
   logic        overflow_err;

   int checks = 0;
   int errors = 0;

   recirculador_param #(
      .NUM_CH(4), .DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(4)
   ) dut (
      .clk(clk), .reset(reset), .active(active),
      .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in),
      .valid_out_activo(valid_out_activo), .data_out_activo(data_out_activo),
      .valid_out_desactivado(valid_out_desactivado),
      .data_out_desactivado(data_out_desactivado),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .state(state),
      .recirc_count(recirc_count), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; active = 1'b0; valid_in = '0; data_in = '0; ready_in = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; active = 1'b0; valid_in = 4'b1111; data_in = 32'hFFFF_FFFF; ready_in = '0;
      tick(); tick();
      valid_in = '0; data_in = '0;
      checks++;
      if ({state, fifo_empty, fifo_full, valid_out_activo, valid_out_desactivado} !== 18'h0F000) begin
         errors++; $display("FAIL reset_flags got %h want %h",
            {state, fifo_empty, fifo_full, valid_out_activo, valid_out_desactivado}, 18'h0F000);
      end
      checks++;
      if ({recirc_count, overflow_err, data_out_desactivado, data_out_activo} !== 69'h0) begin
         errors++; $display("FAIL reset_data got %h want 0",
            {recirc_count, overflow_err, data_out_desactivado, data_out_activo});
      end
      reset = 1'b0; active = 1'b0;
      valid_in = 4'b1001; data_in = 32'h3C00_00A5;
      tick();
      valid_in = '0; data_in = '0;
      checks++;
      if (valid_out_desactivado !== 4'b1001 || data_out_desactivado !== 32'h3C00_00A5) begin
         errors++; $display("FAIL idle_recirc got %b/%h want 1001/3c0000a5",
            valid_out_desactivado, data_out_desactivado);
      end
      checks++;
      if (recirc_count !== 4'd2 || state !== 2'd0 || valid_out_activo !== 4'b0000) begin
         errors++; $display("FAIL idle_status got cnt=%0d st=%0d va=%b want 2/0/0000",
            recirc_count, state, valid_out_activo);
      end
      tick();
      checks++;
      if (valid_out_desactivado !== 4'b0000 || data_out_desactivado !== 32'h0) begin
         errors++; $display("FAIL idle_clear got %b/%h want 0000/0",
            valid_out_desactivado, data_out_desactivado);
      end
   endtask

   task automatic test_active_pass();
      do_reset();
      active = 1'b1; ready_in = 4'hF;
      tick();
      checks++;
      if (state !== 2'd1) begin
         errors++; $display("FAIL pass_state got %0d want 1", state);
      end
      for (int k = 1; k <= 8; k++) begin
         valid_in = 4'b0010; data_in = 32'(k) << 8;
         tick();
         checks++;
         if (valid_out_activo[1] !== 1'b1 || data_out_activo[15:8] !== 8'(k)) begin
            errors++; $display("FAIL pass_word%0d got v=%b d=%h want 1/%h",
               k, valid_out_activo[1], data_out_activo[15:8], 8'(k));
         end
      end
      valid_in = '0; data_in = '0;
      tick();
      checks++;
      if (fifo_empty !== 4'hF || recirc_count !== 4'd0 || valid_out_desactivado !== 4'b0) begin
         errors++; $display("FAIL pass_end got e=%b cnt=%0d vd=%b want 1111/0/0000",
            fifo_empty, recirc_count, valid_out_desactivado);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      active = 1'b1; ready_in = 4'b1011;
      tick();
      for (int k = 0; k < 6; k++) begin
         valid_in = 4'b0100; data_in = 32'(8'h10 + k) << 16;
         tick();
         if (k == 3) begin
            checks++;
            if (fifo_full[2] !== 1'b1 || overflow_err !== 1'b0) begin
               errors++; $display("FAIL ovf_fill got full=%b err=%b want 1/0",
                  fifo_full[2], overflow_err);
            end
         end
         if (k >= 4) begin
            checks++;
            if (valid_out_desactivado !== 4'b0100 || data_out_desactivado[23:16] !== 8'(8'h10 + k)) begin
               errors++; $display("FAIL ovf_divert%0d got %b/%h want 0100/%h",
                  k, valid_out_desactivado, data_out_desactivado[23:16], 8'(8'h10 + k));
            end
         end
      end
      valid_in = '0; data_in = '0;
      checks++;
      if (overflow_err !== 1'b1 || recirc_count !== 4'd2 || fifo_full !== 4'b0100) begin
         errors++; $display("FAIL ovf_status got err=%b cnt=%0d full=%b want 1/2/0100",
            overflow_err, recirc_count, fifo_full);
      end
      ready_in[2] = 1'b1;
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (valid_out_activo[2] !== 1'b1 || data_out_activo[23:16] !== 8'(8'h10 + j)) begin
            errors++; $display("FAIL ovf_content%0d got v=%b d=%h want 1/%h",
               j, valid_out_activo[2], data_out_activo[23:16], 8'(8'h10 + j));
         end
         tick();
      end
      checks++;
      if (fifo_empty[2] !== 1'b1 || overflow_err !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky got empty=%b err=%b want 1/1", fifo_empty[2], overflow_err);
      end
   endtask

   task automatic test_full_pop();
      do_reset();
      active = 1'b1; ready_in = 4'b0000;
      tick();
      for (int k = 0; k < 4; k++) begin
         valid_in = 4'b0100; data_in = 32'(8'h10 + k) << 16;
         tick();
      end
      ready_in = 4'b0100; valid_in = 4'b0100; data_in = 32'h0020_0000;
      tick();
      valid_in = '0; data_in = '0;
      checks++;
      if (valid_out_desactivado !== 4'b0100 || data_out_desactivado[23:16] !== 8'h20) begin
         errors++; $display("FAIL fullpop_divert got %b/%h want 0100/20",
            valid_out_desactivado, data_out_desactivado[23:16]);
      end
      checks++;
      if (fifo_full[2] !== 1'b0 || data_out_activo[23:16] !== 8'h11) begin
         errors++; $display("FAIL fullpop_head got full=%b d=%h want 0/11",
            fifo_full[2], data_out_activo[23:16]);
      end
      tick(); tick();
      checks++;
      if (fifo_empty[2] !== 1'b0 || data_out_activo[23:16] !== 8'h13) begin
         errors++; $display("FAIL fullpop_last got empty=%b d=%h want 0/13",
            fifo_empty[2], data_out_activo[23:16]);
      end
      tick();
      checks++;
      if (fifo_empty[2] !== 1'b1) begin
         errors++; $display("FAIL fullpop_occ3 got empty=%b want 1", fifo_empty[2]);
      end
   endtask

   task automatic test_drain();
      do_reset();
      active = 1'b1; ready_in = 4'b0000;
      tick();
      for (int k = 0; k < 3; k++) begin
         valid_in = 4'b0001; data_in = 32'(8'h30 + k);
         tick();
      end
      valid_in = '0; data_in = '0;
      active = 1'b0; ready_in = 4'b0001;
      tick();
      checks++;
      if (state !== 2'd2 || data_out_activo[7:0] !== 8'h31) begin
         errors++; $display("FAIL drain_enter got st=%0d d=%h want 2/31", state, data_out_activo[7:0]);
      end
      valid_in = 4'b0010; data_in = 32'h0000_4400;
      tick();
      valid_in = '0; data_in = '0;
      checks++;
      if (valid_out_desactivado !== 4'b0010 || data_out_desactivado[15:8] !== 8'h44 ||
          fifo_empty[1] !== 1'b1 || data_out_activo[7:0] !== 8'h32) begin
         errors++; $display("FAIL drain_input got vd=%b d=%h e1=%b head=%h want 0010/44/1/32",
            valid_out_desactivado, data_out_desactivado[15:8], fifo_empty[1], data_out_activo[7:0]);
      end
      tick();
      checks++;
      if (state !== 2'd2 || fifo_empty !== 4'hF) begin
         errors++; $display("FAIL drain_empty got st=%0d e=%b want 2/1111", state, fifo_empty);
      end
      tick();
      checks++;
      if (state !== 2'd0) begin
         errors++; $display("FAIL drain_exit got %0d want 0", state);
      end

      do_reset();
      active = 1'b1; ready_in = 4'b0000;
      tick();
      for (int k = 0; k < 2; k++) begin
         valid_in = 4'b0001; data_in = 32'(8'h50 + k);
         tick();
      end
      valid_in = '0; data_in = '0;
      active = 1'b0;
      tick();
      active = 1'b1;
      tick();
      checks++;
      if (state !== 2'd1 || valid_out_activo[0] !== 1'b1 || data_out_activo[7:0] !== 8'h50) begin
         errors++; $display("FAIL drain_reactivate got st=%0d v=%b d=%h want 1/1/50",
            state, valid_out_activo[0], data_out_activo[7:0]);
      end
      ready_in = 4'b0001;
      tick();
      checks++;
      if (data_out_activo[7:0] !== 8'h51 || fifo_empty[0] !== 1'b0) begin
         errors++; $display("FAIL drain_preserve got d=%h e=%b want 51/0",
            data_out_activo[7:0], fifo_empty[0]);
      end
   endtask

   task automatic test_saturation();
      logic [3:0] exp_cnt [5];
      exp_cnt = '{4'd4, 4'd8, 4'd12, 4'd15, 4'd15};
      do_reset();
      valid_in = 4'hF; data_in = 32'h0403_0201;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (recirc_count !== exp_cnt[k]) begin
            errors++; $display("FAIL sat_cycle%0d got %0d want %0d", k, recirc_count, exp_cnt[k]);
         end
      end
      valid_in = '0; data_in = '0;
      checks++;
      if (overflow_err !== 1'b0 || data_out_desactivado !== 32'h0403_0201) begin
         errors++; $display("FAIL sat_misc got err=%b d=%h want 0/04030201",
            overflow_err, data_out_desactivado);
      end
   endtask

   initial begin
      reset = 1'b1; active = 1'b0; valid_in = '0; data_in = '0; ready_in = '0;
      test_reset();
      test_active_pass();
      test_overflow();
      test_full_pop();
      test_drain();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
